// File: rtl/csc_enc_deadlock_scan_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csc_enc_deadlock_scan_ctrl_if : deadlock report valid/ready channel
// Rev 1.0
// ---------------------------------------------------------------------------
interface csc_enc_deadlock_scan_ctrl_if #(
  parameter int NUM_MON = 4,
  parameter int CYC_W   = 16
);
  localparam int IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;

  logic             rpt_valid;
  logic             rpt_ready;
  logic [IDX_W-1:0] rpt_idx;
  logic [CYC_W-1:0] rpt_cycles;

  modport master (output rpt_valid, rpt_idx, rpt_cycles, input rpt_ready);
  modport slave  (input rpt_valid, rpt_idx, rpt_cycles, output rpt_ready);
endinterface
`default_nettype wire

// File: rtl/csc_enc_deadlock_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csc_enc_deadlock_scan_ctrl : persistence-qualified deadlock detector with
// round-robin per-monitor report serializer. Option: CSC_ENC_DL_STICKY_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module csc_enc_deadlock_scan_ctrl #(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 16,
  parameter int CYC_W   = 16
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               enable_i,
  input  wire logic               clear_i,
  input  wire logic [NUM_MON-1:0] mon_block_i,
  output logic                    dl_flag_o,
  csc_enc_deadlock_scan_ctrl_if.master rpt
);
  localparam int IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
  localparam logic [IDX_W-1:0]   IDX_ONE  = 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_MON - 1);
  localparam logic [CYC_W-1:0]   CYC_ONE  = 1;
  localparam logic [NUM_MON-1:0] SNAP_ONE = 1;
  localparam logic [7:0]         PERSIST_LAST = 8'(THRESH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WATCH  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_REPORT = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         persist_q, persist_d;
  logic [CYC_W-1:0]   stall_q, stall_d;
  logic [NUM_MON-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               dl_q, valid_q;
  logic               xfer;
  logic [NUM_MON-1:0] snap_after_xfer;

  assign xfer            = (state_q == ST_REPORT) && rpt.rpt_ready;
  assign snap_after_xfer = snap_q & ~(SNAP_ONE << idx_q);

  always_comb begin
    state_d   = state_q;
    persist_d = persist_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cyc_d     = cyc_q;
    case (state_q)
      ST_IDLE: begin
        persist_d = 8'd0;
        if (enable_i && (|mon_block_i)) begin
          state_d   = ST_WATCH;
          persist_d = 8'd1;
        end
      end
      ST_WATCH: begin
        if (!enable_i || !(|mon_block_i)) begin
          state_d = ST_IDLE;
        end else if (persist_q == PERSIST_LAST) begin
          snap_d  = mon_block_i;
          state_d = ST_SCAN;
        end else begin
          persist_d = persist_q + 8'd1;
        end
      end
      ST_SCAN: begin
        if (snap_q[ptr_q]) begin
          idx_d   = ptr_q;
          cyc_d   = stall_q;
          state_d = ST_REPORT;
        end else begin
          ptr_d = (ptr_q == IDX_LAST) ? '0 : ptr_q + IDX_ONE;
        end
      end
      ST_REPORT: begin
        if (xfer) begin
          snap_d  = snap_after_xfer;
          ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
          state_d = (|snap_after_xfer) ? ST_SCAN : ST_HOLD;
        end
      end
      ST_HOLD: begin
`ifndef CSC_ENC_DL_STICKY_EN
        if (!(|mon_block_i)) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // A transfer coinciding with clear still retires its bit and moves ptr.
    if (clear_i) begin
      state_d   = ST_IDLE;
      persist_d = 8'd0;
      if (state_q != ST_REPORT) begin
        ptr_d = ptr_q;
        idx_d = idx_q;
        cyc_d = cyc_q;
      end
    end

    stall_d = (state_d == ST_IDLE) ? '0 :
              ((stall_q == '1) ? stall_q : stall_q + CYC_ONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      persist_q <= 8'd0;
      stall_q   <= '0;
      snap_q    <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      cyc_q     <= '0;
      dl_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      persist_q <= persist_d;
      stall_q   <= stall_d;
      snap_q    <= snap_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cyc_q     <= cyc_d;
      dl_q      <= (state_d == ST_SCAN) || (state_d == ST_REPORT) || (state_d == ST_HOLD);
      valid_q   <= (state_d == ST_REPORT);
    end
  end

  assign dl_flag_o      = dl_q;
  assign rpt.rpt_valid  = valid_q;
  assign rpt.rpt_idx    = idx_q;
  assign rpt.rpt_cycles = cyc_q;
endmodule
`default_nettype wire

// File: tb/tb_csc_enc_deadlock_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_csc_enc_deadlock_scan_ctrl : directed + randomized bench with an
// episode-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_csc_enc_deadlock_scan_ctrl;
  localparam int N  = 4;
  localparam int TH = 16;
  localparam int CW = 16;

  localparam int PH_IDLE = 0, PH_WATCH = 1, PH_SEARCH = 2, PH_REPORT = 3, PH_HOLD = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         clear;
  logic [N-1:0] mon_block;
  logic         dl_flag;

  always #5 clock = ~clock;

  csc_enc_deadlock_scan_ctrl_if #(.NUM_MON(N), .CYC_W(CW)) rpt_bus ();

  csc_enc_deadlock_scan_ctrl #(.NUM_MON(N), .THRESH(TH), .CYC_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable_i    (enable),
    .clear_i     (clear),
    .mon_block_i (mon_block),
    .dl_flag_o   (dl_flag),
    .rpt         (rpt_bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks the episode, not the RTL's encoding. A search is
  // resolved up front as "first set bit at or after ptr, circularly".
  int     m_ph, m_persist, m_stall, m_ptr, m_miss, m_target, m_idx, m_cyc;
  bit [N-1:0] m_snap;

  function automatic void m_reset();
    m_ph = PH_IDLE; m_persist = 0; m_stall = 0; m_ptr = 0;
    m_miss = 0; m_target = 0; m_idx = 0; m_cyc = 0; m_snap = '0;
  endfunction

  function automatic void m_start_search();
    m_ph = PH_SEARCH;
    for (int d = N - 1; d >= 0; d--)
      if (m_snap[(m_ptr + d) % N]) begin
        m_target = (m_ptr + d) % N;
        m_miss   = d;
      end
  endfunction

  function automatic void model_step(input logic en, input logic clr,
                                     input logic [N-1:0] mb, input logic rdy);
    case (m_ph)
      PH_IDLE:
        if (!clr && en && mb != 0) begin m_ph = PH_WATCH; m_persist = 1; end
      PH_WATCH:
        if (clr || !en || mb == 0) m_ph = PH_IDLE;
        else begin
          m_persist++;
          if (m_persist == TH) begin m_snap = mb; m_start_search(); end
        end
      PH_SEARCH:
        if (clr) m_ph = PH_IDLE;
        else if (m_miss == 0) begin
          m_idx = m_target; m_cyc = m_stall; m_ph = PH_REPORT;
        end else begin
          m_miss--; m_ptr = (m_ptr + 1) % N;
        end
      PH_REPORT: begin
        if (rdy) begin m_snap[m_idx] = 1'b0; m_ptr = (m_idx + 1) % N; end
        if (clr) m_ph = PH_IDLE;
        else if (rdy) begin
          if (m_snap != 0) m_start_search(); else m_ph = PH_HOLD;
        end
      end
      default: begin
`ifdef CSC_ENC_DL_STICKY_EN
        if (clr) m_ph = PH_IDLE;
`else
        if (clr || mb == 0) m_ph = PH_IDLE;
`endif
      end
    endcase
    if (m_ph == PH_IDLE) m_stall = 0;
    else if (m_stall < (1 << CW) - 1) m_stall++;
  endfunction

  task automatic cycle(input logic en, input logic clr, input logic [N-1:0] mb, input logic rdy);
    enable = en; clear = clr; mon_block = mb; rpt_bus.rpt_ready = rdy;
    @(posedge clock);
    model_step(en, clr, mb, rdy);
    @(negedge clock);
    check("dl_flag",    {31'd0, dl_flag},           {31'd0, m_ph >= PH_SEARCH});
    check("rpt_valid",  {31'd0, rpt_bus.rpt_valid}, {31'd0, m_ph == PH_REPORT});
    check("rpt_idx",    32'(rpt_bus.rpt_idx),       32'(m_idx));
    check("rpt_cycles", 32'(rpt_bus.rpt_cycles),    32'(m_cyc));
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; mon_block = '0; rpt_bus.rpt_ready = 1'b0;
    repeat (3) @(posedge clock);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int           seen[$];
    logic         any_dl;
    logic [N-1:0] mb_r;
    logic         en_r, clr_r, rdy_r;

    do_reset();
    check("rst_dl_flag",    {31'd0, dl_flag},           32'd0);
    check("rst_rpt_valid",  {31'd0, rpt_bus.rpt_valid}, 32'd0);
    check("rst_rpt_idx",    32'(rpt_bus.rpt_idx),       32'd0);
    check("rst_rpt_cycles", 32'(rpt_bus.rpt_cycles),    32'd0);

    // Single blocked monitor: flag in cycle 16, report idx 2 in cycle 19.
    for (int t = 0; t < 21; t++) begin
      cycle(1'b1, 1'b0, 4'b0100, 1'b1);
      if (t == 14) check("dl_before_thresh", {31'd0, dl_flag}, 32'd0);
      if (t == 15) check("dl_at_thresh", {31'd0, dl_flag}, 32'd1);
      if (t == 17) check("valid_c18", {31'd0, rpt_bus.rpt_valid}, 32'd0);
      if (t == 18) begin
        check("valid_c19", {31'd0, rpt_bus.rpt_valid}, 32'd1);
        check("idx_c19",   32'(rpt_bus.rpt_idx), 32'd2);
        check("cyc_c19",   32'(rpt_bus.rpt_cycles), 32'd18);
      end
      if (t == 20) check("hold_valid", {31'd0, rpt_bus.rpt_valid}, 32'd0);
    end
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
`ifdef CSC_ENC_DL_STICKY_EN
    check("hold_exit_dl", {31'd0, dl_flag}, 32'd1);
`else
    check("hold_exit_dl", {31'd0, dl_flag}, 32'd0);
`endif

    // Multi-monitor snapshot from reset: round-robin order 0,1,3.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      cycle(1'b1, 1'b0, 4'b1011, 1'b1);
      if (rpt_bus.rpt_valid) seen.push_back(int'(rpt_bus.rpt_idx));
    end
    check("rr_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("rr_0", 32'(seen[0]), 32'd0);
      check("rr_1", 32'(seen[1]), 32'd1);
      check("rr_2", 32'(seen[2]), 32'd3);
    end

    // Short blockage and enable drop never declare a deadlock.
    do_reset();
    any_dl = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < TH + 4; t++) begin
        if (r == 0) cycle(1'b1, 1'b0, (t < TH - 1) ? 4'b0001 : 4'b0000, 1'b1);
        else        cycle(t != 8, 1'b0, 4'b0110, 1'b1);
        any_dl |= dl_flag;
      end
      cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    end
    check("no_deadlock", {31'd0, any_dl}, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    mb_r = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 8) mb_r = ($urandom_range(9) < 3) ? '0 : N'($urandom);
      en_r  = ($urandom_range(99) < 97);
      clr_r = ($urandom_range(99) < 2) && (m_ph != PH_SEARCH);
      rdy_r = ($urandom_range(99) < 60);
      cycle(en_r, clr_r, mb_r, rdy_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/csc_enc_deadlock_scan_ctrl.md
# csc_enc_deadlock_scan_ctrl

Deadlock-report scheduler for the csc_enc HLS deadlock monitor tree. Collects per-process `block` outputs from up to NUM_MON deadlock monitors and qualifies them with a persistence threshold. Once a deadlock is confirmed it raises a flag, then serializes one report per blocked monitor, round-robin, over a valid/ready channel to the debug/status logic.

## Interface
- NUM_MON, 4, number of monitor inputs (2..16)
- THRESH, 16, consecutive cycles with any monitor blocked before deadlock is declared (2..255)
- CYC_W, 16, width of the stall-cycle counter
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  arms detection; low holds the block in IDLE (see Operation)
- clear  in  1  pulse; aborts any activity, returns to IDLE next cycle
- mon_block  in  NUM_MON  block flags from monitors, bit i = monitor i
- dl_flag  out  1  deadlock confirmed
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report
- rpt_idx  out  clog2(NUM_MON)  index of blocked monitor being reported
- rpt_cycles  out  CYC_W  stall cycles counted when the report was formed

## Operation
- States: IDLE, WATCH, SCAN, REPORT, HOLD.
- IDLE:
  - persist=0, stall counter=0.
  - If enable && |mon_block: go to WATCH with persist=1.
- WATCH:
  - If |mon_block: persist++; when persist reaches THRESH, snapshot<=mon_block and go to SCAN.
  - If mon_block==0 or !enable: go to IDLE.
- SCAN:
  - Tests snapshot[ptr], one index per cycle.
  - If set: rpt_idx<=ptr, rpt_cycles<=stall counter, go to REPORT.
  - Else: ptr<=ptr+1, wrapping at NUM_MON.
  - ptr resets to 0 and persists across deadlock episodes. Each next scan starts at last reported index+1.
- REPORT:
  - rpt_valid=1 with rpt_idx/rpt_cycles stable until rpt_valid&&rpt_ready.
  - On transfer, clear snapshot[rpt_idx] and set ptr<=rpt_idx+1.
  - Then go to SCAN if the snapshot is still nonzero, else to HOLD.
- HOLD: no reports. Exit behaviour depends on Configuration.
- Stall counter: increments every cycle outside IDLE, saturates at all-ones.
- dl_flag=1 in SCAN, REPORT and HOLD; 0 in IDLE and WATCH.
- enable is ignored in SCAN, REPORT and HOLD.
- clear has priority over all transitions.
  - In REPORT it may drop rpt_valid without a transfer.
  - If clear and a transfer coincide, the transfer counts and the next state is IDLE.
- mon_block changes after the snapshot do not alter the current episode's report set.

## Timing
- Reset: state IDLE, dl_flag=0, rpt_valid=0, rpt_idx=0, rpt_cycles=0, ptr=0.
- If mon_block is first nonzero in cycle 0 and stays nonzero, WATCH occupies cycles 1..THRESH-1 and dl_flag rises in cycle THRESH.
- Worst-case SCAN latency is NUM_MON cycles. rpt_valid rises the cycle after the hit index is tested.
- With rpt_ready held high, a transfer takes 1 cycle and the next report follows after 1+k cycles, where k is the number of clear bits skipped.
- Outputs are registered; no combinational path from rpt_ready to rpt_valid.

## Configuration
- CSC_ENC_DL_STICKY_EN defined:
  - HOLD is exited only by clear or reset.
  - dl_flag stays high indefinitely.
- CSC_ENC_DL_STICKY_EN undefined:
  - HOLD goes to IDLE the cycle after mon_block==0 is sampled.
  - A later block starts a new episode, with the stall counter restarting at 0.

## Test plan
- NUM_MON=4, THRESH=16, enable=1, mon_block=4'b0100 from cycle 0, rpt_ready=1 -> dl_flag rises cycle 16; rpt_valid cycle 19 with rpt_idx=2, rpt_cycles=18; then HOLD.
- mon_block=4'b1011 at threshold, rpt_ready=1 -> reports idx 0, 1, 3 in order, one per transfer; snapshot empty -> HOLD.
- mon_block nonzero for 15 cycles then 0 -> returns to IDLE, dl_flag never asserts; repeat with enable dropped mid-WATCH -> same result.
- rpt_ready low for 10 cycles during REPORT -> rpt_valid, rpt_idx, rpt_cycles stable for all 10 cycles; transfer on the first ready cycle.
- clear asserted in REPORT, once coinciding with a transfer and once without -> IDLE next cycle in both cases; dl_flag=0; ptr retained (next episode starts at the retained ptr).
- HOLD then mon_block=0 -> IDLE after 1 cycle if CSC_ENC_DL_STICKY_EN is undefined; with it defined, dl_flag stays 1 until clear.
